// File: rtl/jtag_tap_driver_if.sv
// Command/response bundle between a JTAG sequence requester and jtag_tap_driver.
interface jtag_tap_driver_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [5:0]  cmd_len;
  logic [63:0] cmd_data;
  logic        rsp_valid;
  logic [63:0] rsp_data;
  logic        busy;

  modport master (
    output cmd_valid, cmd_op, cmd_len, cmd_data,
    input  cmd_ready, rsp_valid, rsp_data, busy
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_len, cmd_data,
    output cmd_ready, rsp_valid, rsp_data, busy
  );
endinterface

// File: rtl/jtag_tap_driver.sv
// JTAG initiator: walks the TAP through reset/IR/DR/idle sequences from wb_clk_i and
// returns the TDO bits captured during the shift cycles.
module jtag_tap_driver #(
  parameter int unsigned TCK_DIV = 2
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_ni,
  jtag_tap_driver_if.slave   bus,
  output logic               tck_o,
  output logic               tms_o,
  output logic               tdi_o,
  input  logic               tdo_i
);

  localparam int unsigned    DivW   = (TCK_DIV > 1) ? $clog2(TCK_DIV) : 1;
  localparam logic [DivW-1:0] DivMax = DivW'(TCK_DIV - 1);

  typedef enum logic [1:0] {OpReset = 2'd0, OpShiftIr = 2'd1, OpShiftDr = 2'd2, OpIdle = 2'd3} op_e;
  typedef enum logic [1:0] {StIdle, StSeq, StDone, StResp} state_e;

  // TCK cycles spent walking from Run-Test/Idle into Shift-xR.
  function automatic logic [6:0] pre_cycles(op_e op);
    case (op)
      OpShiftDr: return 7'd3;
      OpShiftIr: return 7'd4;
      default:   return 7'd0;
    endcase
  endfunction

  function automatic logic [6:0] seq_len(op_e op, logic [5:0] len);
    case (op)
      OpReset: return 7'd6;
      OpIdle:  return {1'b0, len} + 7'd1;
      default: return pre_cycles(op) + {1'b0, len} + 7'd3;
    endcase
  endfunction

  function automatic logic is_shift(op_e op, logic [5:0] len, logic [6:0] k);
    logic [6:0] pre;
    pre = pre_cycles(op);
    return (op == OpShiftDr || op == OpShiftIr) && (k >= pre) && (k <= pre + {1'b0, len});
  endfunction

  function automatic logic tms_at(op_e op, logic [5:0] len, logic [6:0] k);
    logic [6:0] pre;
    logic [6:0] last;
    pre  = pre_cycles(op);
    last = pre + {1'b0, len};
    case (op)
      OpReset: return k < 7'd5;
      OpIdle:  return 1'b0;
      default: begin
        if (k < pre)        return (k == 7'd0) || (op == OpShiftIr && k == 7'd1);
        else if (k <= last) return k == last;
        else                return k == last + 7'd1;
      end
    endcase
  endfunction

  state_e          state_q;
  op_e             op_q;
  logic            auto_q;
  logic [5:0]      len_q;
  logic [63:0]     data_q;
  logic [63:0]     cap_q;
  logic [6:0]      cyc_q;
  logic [DivW-1:0] div_q;
  logic            tck_q, tms_q, tdi_q;
  logic            ready_q, busy_q, rsp_valid_q;
  logic [63:0]     rsp_data_q;

  op_e        cmd_op;
  logic [6:0] cyc_nxt;
  logic [5:0] idx_cur, idx_nxt;
  logic       shift_cur, shift_nxt, tms_nxt, last_cyc;

  assign cmd_op    = op_e'(bus.cmd_op);
  assign cyc_nxt   = cyc_q + 7'd1;
  assign idx_cur   = 6'(cyc_q - pre_cycles(op_q));
  assign idx_nxt   = 6'(cyc_nxt - pre_cycles(op_q));
  assign shift_cur = is_shift(op_q, len_q, cyc_q);
  assign shift_nxt = is_shift(op_q, len_q, cyc_nxt);
  assign tms_nxt   = tms_at(op_q, len_q, cyc_nxt);
  assign last_cyc  = (cyc_q == seq_len(op_q, len_q) - 7'd1);

  // Reset lands directly in the sequencer running a RESET walk (auto-reset, no response).
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q     <= StSeq;
      op_q        <= OpReset;
      auto_q      <= 1'b1;
      len_q       <= '0;
      data_q      <= '0;
      cap_q       <= '0;
      cyc_q       <= '0;
      div_q       <= '0;
      tck_q       <= 1'b0;
      tms_q       <= 1'b1;
      tdi_q       <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.cmd_valid && ready_q) begin
            op_q    <= cmd_op;
            len_q   <= bus.cmd_len;
            data_q  <= bus.cmd_data;
            cap_q   <= '0;
            cyc_q   <= '0;
            div_q   <= '0;
            tms_q   <= tms_at(cmd_op, bus.cmd_len, 7'd0);
            tdi_q   <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= StSeq;
          end
        end
        StSeq: begin
          if (div_q != DivMax) begin
            div_q <= div_q + 1'b1;
          end else begin
            div_q <= '0;
            tck_q <= ~tck_q;
            if (!tck_q) begin
              if (shift_cur) cap_q[idx_cur] <= tdo_i;
            end else if (last_cyc) begin
              tms_q   <= 1'b0;
              tdi_q   <= 1'b0;
              state_q <= StDone;
            end else begin
              cyc_q <= cyc_nxt;
              tms_q <= tms_nxt;
              tdi_q <= shift_nxt & data_q[idx_nxt];
            end
          end
        end
        StDone: begin
          if (!auto_q) begin
            rsp_valid_q <= 1'b1;
            rsp_data_q  <= cap_q;
          end
          state_q <= StResp;
        end
        default: begin
          rsp_valid_q <= 1'b0;
          ready_q     <= 1'b1;
          busy_q      <= 1'b0;
          auto_q      <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign tck_o         = tck_q;
  assign tms_o         = tms_q;
  assign tdi_o         = tdi_q;
  assign bus.cmd_ready = ready_q;
  assign bus.busy      = busy_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_jtag_tap_driver.sv
// Bench for jtag_tap_driver: two instances (TCK_DIV=1 and 3) driven from a vector table,
// random commands and hand-written reset/hold sequences, checked against a sequence model.
module tb_jtag_tap_driver;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  jtag_tap_driver_if if1 ();
  jtag_tap_driver_if if3 ();
  logic tck1, tms1, tdi1, tdo1;
  logic tck3, tms3, tdi3, tdo3;
  int   tdo_mode;  // 0 loopback, 1 constant one, 2 random per TCK cycle
  logic tdo_rand = 1'b0;
  bit   sel;       // 0 selects the TCK_DIV=1 instance, 1 the TCK_DIV=3 instance

  assign tdo1 = (tdo_mode == 0) ? tdi1 : (tdo_mode == 1) ? 1'b1 : tdo_rand;
  assign tdo3 = (tdo_mode == 0) ? tdi3 : (tdo_mode == 1) ? 1'b1 : tdo_rand;

  jtag_tap_driver #(.TCK_DIV(1)) u_dut1 (
    .wb_clk_i (clk), .wb_rst_ni (rst_n), .bus (if1),
    .tck_o (tck1), .tms_o (tms1), .tdi_o (tdi1), .tdo_i (tdo1)
  );
  jtag_tap_driver #(.TCK_DIV(3)) u_dut3 (
    .wb_clk_i (clk), .wb_rst_ni (rst_n), .bus (if3),
    .tck_o (tck3), .tms_o (tms3), .tdi_o (tdi3), .tdo_i (tdo3)
  );

  logic        m_tck, m_tms, m_tdi, m_ready, m_busy, m_rsp_valid, m_valid;
  logic [63:0] m_rsp_data;
  assign m_tck       = sel ? tck3 : tck1;
  assign m_tms       = sel ? tms3 : tms1;
  assign m_tdi       = sel ? tdi3 : tdi1;
  assign m_ready     = sel ? if3.cmd_ready : if1.cmd_ready;
  assign m_busy      = sel ? if3.busy : if1.busy;
  assign m_rsp_valid = sel ? if3.rsp_valid : if1.rsp_valid;
  assign m_rsp_data  = sel ? if3.rsp_data : if1.rsp_data;
  assign m_valid     = sel ? if3.cmd_valid : if1.cmd_valid;

  always @(negedge m_tck) tdo_rand = 1'($urandom);

  // Observation of the selected instance, sampled mid-cycle.
  bit           rec;
  logic         prev_tck = 1'b0;
  int           nrise, since_rise, high_run, tbad, rsp_cnt, acc_cnt;
  logic [127:0] obs_tms, obs_tdi, obs_tdo;

  always @(negedge clk) begin
    if (rec) begin
      if (m_rsp_valid) rsp_cnt++;
      if (m_valid && m_ready) acc_cnt++;
      if (m_tck && !prev_tck) begin
        if (nrise > 0 && since_rise != 2 * (sel ? 3 : 1)) tbad++;
        since_rise = 1;
        if (nrise < 128) begin
          obs_tms[nrise] = m_tms;
          obs_tdi[nrise] = m_tdi;
          obs_tdo[nrise] = (tdo_mode == 2) ? tdo_rand : 1'b0;
        end
        nrise++;
      end else begin
        since_rise++;
      end
      if (!m_tck && prev_tck && high_run != (sel ? 3 : 1)) tbad++;
      high_run = m_tck ? high_run + 1 : 0;
    end
    prev_tck = m_tck;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_obs();
    nrise = 0; since_rise = 0; high_run = 0; tbad = 0; rsp_cnt = 0; acc_cnt = 0;
    obs_tms = '0; obs_tdi = '0; obs_tdo = '0;
  endtask

  task automatic drive(input bit v, input logic [1:0] op, input logic [5:0] len,
                       input logic [63:0] d);
    if (sel) begin
      if3.cmd_valid = v; if3.cmd_op = op; if3.cmd_len = len; if3.cmd_data = d;
    end else begin
      if1.cmd_valid = v; if1.cmd_op = op; if1.cmd_len = len; if1.cmd_data = d;
    end
  endtask

  task automatic wait_ready(input string tag, output bit ok);
    int n;
    n = 0;
    while (!m_ready && n < 3000) begin
      tick();
      n++;
    end
    ok = m_ready;
    if (!ok) chk({tag, "_ready_timeout"}, 128'(m_ready), 128'(1));
  endtask

  // Reference: TMS/TDI per TCK cycle and expected capture, built from the sequence rules.
  logic [127:0] exp_tms, exp_tdi;
  logic [63:0]  exp_rsp;
  int           exp_n;

  task automatic push(input logic t, input logic d);
    exp_tms[exp_n] = t;
    exp_tdi[exp_n] = d;
    exp_n++;
  endtask

  task automatic shift_bits(input int nb, input logic [63:0] data, input int mode);
    int pre;
    pre = exp_n;
    for (int i = 0; i < nb; i++) begin
      push(i == nb - 1, data[i]);
      exp_rsp[i] = (mode == 0) ? data[i] : (mode == 1) ? 1'b1 : obs_tdo[pre + i];
    end
  endtask

  task automatic model(input logic [1:0] op, input logic [5:0] len, input logic [63:0] data,
                       input int mode);
    int nb;
    nb = int'(len) + 1;
    exp_n = 0; exp_tms = '0; exp_tdi = '0; exp_rsp = '0;
    case (op)
      2'd0: begin
        for (int i = 0; i < 5; i++) push(1'b1, 1'b0);
        push(1'b0, 1'b0);
      end
      2'd1: begin
        push(1'b1, 1'b0); push(1'b1, 1'b0); push(1'b0, 1'b0); push(1'b0, 1'b0);
        shift_bits(nb, data, mode);
        push(1'b1, 1'b0); push(1'b0, 1'b0);
      end
      2'd2: begin
        push(1'b1, 1'b0); push(1'b0, 1'b0); push(1'b0, 1'b0);
        shift_bits(nb, data, mode);
        push(1'b1, 1'b0); push(1'b0, 1'b0);
      end
      default: for (int i = 0; i < nb; i++) push(1'b0, 1'b0);
    endcase
  endtask

  logic [63:0] last_rsp;
  int          last_n;

  task automatic run_cmd(input logic [1:0] op, input logic [5:0] len, input logic [63:0] data,
                         input int mode, input bit hold, input string tag);
    bit ok;
    int n;
    tdo_mode = mode;
    wait_ready(tag, ok);
    if (!ok) return;
    clear_obs();
    rec = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, op, len, data);
    @(posedge clk); #1;
    if (!hold) drive(1'b0, 2'($urandom), 6'($urandom), {$urandom, $urandom});
    n = 0;
    while (rsp_cnt == 0 && n < 3000) begin
      tick();
      n++;
    end
    chk({tag, "_rsp_seen"}, 128'(rsp_cnt != 0), 128'(1));
    model(op, len, data, mode);
    last_rsp = m_rsp_data;
    last_n   = nrise;
    chk({tag, "_ncycles"}, 128'(nrise), 128'(exp_n));
    chk({tag, "_tms"}, obs_tms, exp_tms);
    chk({tag, "_tdi"}, obs_tdi, exp_tdi);
    chk({tag, "_rsp_data"}, 128'(m_rsp_data), 128'(exp_rsp));
    chk({tag, "_accepts"}, 128'(acc_cnt), 128'(1));
    chk({tag, "_tck_timing"}, 128'(tbad), 128'(0));
    repeat (3) tick();
    chk({tag, "_rsp_pulses"}, 128'(rsp_cnt), 128'(1));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pads_flags"}, 128'({m_tck, m_tms, m_tdi, m_ready, m_rsp_valid, m_busy}),
        128'(6'b010001));
    chk({tag, "_rsp_data"}, 128'(m_rsp_data), 128'(0));
  endtask

  task automatic check_auto(input string tag);
    bit ok;
    wait_ready(tag, ok);
    chk({tag, "_ncycles"}, 128'(nrise), 128'(6));
    chk({tag, "_tms"}, obs_tms, 128'(6'b011111));
    chk({tag, "_no_rsp"}, 128'(rsp_cnt), 128'(0));
    chk({tag, "_busy"}, 128'(m_busy), 128'(0));
  endtask

  typedef struct {
    bit          sel;
    logic [1:0]  op;
    logic [5:0]  len;
    logic [63:0] data;
    int          mode;
    logic [63:0] exp_rsp;
    int          exp_n;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    bit ok;
    int n;

    vecs[0] = '{1'b0, 2'd2, 6'd7,  64'hA5,               0, 64'hA5,               13};
    vecs[1] = '{1'b0, 2'd1, 6'd3,  64'h8,                1, 64'hF,                10};
    vecs[2] = '{1'b1, 2'd2, 6'd63, 64'hDEADBEEF01234567, 0, 64'hDEADBEEF01234567, 69};
    vecs[3] = '{1'b0, 2'd0, 6'd5,  64'h1234,             1, 64'h0,                6};
    vecs[4] = '{1'b1, 2'd1, 6'd0,  64'h1,                1, 64'h1,                7};
    vecs[5] = '{1'b0, 2'd3, 6'd0,  64'hFF,               1, 64'h0,                1};
    vecs[6] = '{1'b0, 2'd1, 6'd63, 64'h0,                1, {64{1'b1}},           70};
    vecs[7] = '{1'b0, 2'd2, 6'd0,  64'h2,                0, 64'h0,                6};

    rst_n = 1'b0;
    tdo_mode = 0;
    sel = 1'b1; drive(1'b0, 2'd0, 6'd0, 64'd0);
    sel = 1'b0; drive(1'b0, 2'd0, 6'd0, 64'd0);
    clear_obs();
    rec = 1'b1;
    repeat (3) tick();
    check_reset_vals("reset");
    chk("reset_div3_ready_busy", 128'({if3.cmd_ready, if3.busy}), 128'(2'b01));
    rst_n = 1'b1;
    check_auto("auto_rst");

    for (int i = 0; i < 8; i++) begin
      sel = vecs[i].sel;
      run_cmd(vecs[i].op, vecs[i].len, vecs[i].data, vecs[i].mode, 1'b0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_table_rsp", i), 128'(last_rsp), 128'(vecs[i].exp_rsp));
      chk($sformatf("vec%0d_table_n", i), 128'(last_n), 128'(vecs[i].exp_n));
    end

    for (int r = 0; r < 24; r++) begin
      sel = 1'($urandom);
      run_cmd(2'($urandom), 6'($urandom), {$urandom, $urandom}, int'($urandom_range(0, 2)),
              1'b0, $sformatf("rand%0d", r));
    end

    // Reset while shifting bit 10 of a 32-bit DR scan.
    sel = 1'b0;
    tdo_mode = 0;
    wait_ready("midrst", ok);
    clear_obs();
    rec = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 2'd2, 6'd31, {$urandom, $urandom});
    @(posedge clk); #1;
    drive(1'b0, 2'd0, 6'd0, 64'd0);
    n = 0;
    while (nrise < 14 && n < 3000) begin
      tick();
      n++;
    end
    chk("midrst_reached_bit10", 128'(nrise), 128'(14));
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midrst");
    tick(); tick();
    clear_obs();
    rst_n = 1'b1;
    check_auto("midrst_auto");

    // cmd_valid held high: one acceptance per completed command.
    sel = 1'b0;
    run_cmd(2'd3, 6'd9, {$urandom, $urandom}, 2, 1'b1, "hold");
    chk("hold_second_accept", 128'(acc_cnt), 128'(2));
    chk("hold_busy_again", 128'({m_busy, m_ready}), 128'(2'b10));
    drive(1'b0, 2'd0, 6'd0, 64'd0);
    n = 0;
    while (rsp_cnt < 2 && n < 3000) begin
      tick();
      n++;
    end
    chk("hold_second_rsp", 128'(rsp_cnt), 128'(2));
    chk("hold_second_data", 128'(m_rsp_data), 128'(0));
    wait_ready("hold_end", ok);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jtag_tap_driver.md
Name: jtag_tap_driver

Overview:
- Synthesizable JTAG initiator that drives the tms/tck/tdi pads of the multicore SoC top and samples tdo.
- Exercises the on-chip TAP and debug interface in simulation, and in FPGA builds without an external cable.
- Runs from the Wishbone system clock.
- Accepts one command at a time (reset, IR scan, DR scan, idle), walks the TAP state machine, and returns captured TDO bits.

Parameters:
- TCK_DIV, 2, wb_clk_i cycles per TCK half-period (min 1); TCK period = 2*TCK_DIV clocks.

Ports:
- wb_clk_i  in  1  system clock.
- wb_rst_ni  in  1  asynchronous, active-low reset.
- cmd_valid_i  in  1  command request.
- cmd_ready_o  out  1  driver can accept a command.
- cmd_op_i  in  2  0=RESET, 1=SHIFT_IR, 2=SHIFT_DR, 3=IDLE.
- cmd_len_i  in  6  value n means n+1 bits or cycles (1..64).
- cmd_data_i  in  64  TDI bits, LSB shifted first.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_data_o  out  64  captured TDO; bit i = i-th shifted bit; bits >= len are 0.
- busy_o  out  1  sequence in progress.
- tck_o  out  1  JTAG clock.
- tms_o  out  1  JTAG mode select.
- tdi_o  out  1  JTAG data in.
- tdo_i  in  1  JTAG data out from the TAP.

Behaviour:
- Reset values (async on wb_rst_ni low):
  - tck_o=0, tms_o=1, tdi_o=0, cmd_ready_o=0, rsp_valid_o=0, rsp_data_o=0, busy_o=1.
  - Internal counters cleared.
- TCK cycle: TCK_DIV clocks with tck_o=0, then TCK_DIV clocks with tck_o=1.
  - tms_o/tdi_o update only on the first clock of the low phase.
  - tdo_i is sampled on the clock where tck_o is registered 0->1.
  - tck_o idles low between commands.
- States: AUTO_RST -> IDLE -> SEQ -> DONE -> IDLE.
- AUTO_RST: entered after reset release.
  - Issues the RESET sequence with no rsp_valid_o.
  - Then IDLE with cmd_ready_o=1, busy_o=0.
- IDLE: cmd_ready_o=1. On cmd_valid_i & cmd_ready_o:
  - latch op/len/data;
  - cmd_ready_o=0, busy_o=1 next cycle;
  - enter SEQ.
- SEQ: per-op TMS bit sequences, one per TCK cycle. The TAP starts and ends in Run-Test/Idle.
  - RESET: 1,1,1,1,1,0 (6 cycles).
  - SHIFT_DR: 1,0,0, then L shift cycles with TMS=0 except last=1, then 1,0. Total L+5.
  - SHIFT_IR: 1,1,0,0, then L shift cycles (last TMS=1), then 1,0. Total L+6.
  - IDLE: L cycles, TMS=0.
  - tdi_o carries data bit k during the k-th shift cycle and is 0 in non-shift cycles.
  - The TDO sampled in shift cycle k is written to rsp_data bit k.
- DONE:
  - One clock after the final high phase ends (tck_o back to 0): rsp_valid_o=1 for exactly one clock.
  - rsp_data_o is valid and held until the next command completes.
  - RESET/IDLE return rsp_data_o=0.
  - cmd_ready_o=1 the clock after the rsp_valid_o pulse.
- cmd_valid_i while busy is ignored, not queued; no backpressure on responses.
- Changes on cmd_* inputs after acceptance have no effect.
- Reset mid-operation:
  - outputs return to reset values immediately;
  - partial rsp_data is discarded, no rsp_valid_o;
  - AUTO_RST runs again.
- Length 64 (code 63) must shift all 64 bits with no counter wrap.

Test Plan:
1. Release reset, TCK_DIV=1 -> tms_o=1,1,1,1,1,0 at 6 rising edges (12 clocks); cmd_ready_o rises; rsp_valid_o stays 0.
2. SHIFT_DR, len code 7, data 0xA5, tdo_i=tdi_o loopback -> TMS 1,0,0,0x7,1,1,0 (13 edges); rsp_data_o=0x00000000000000A5; single rsp_valid_o pulse.
3. SHIFT_IR, len code 3, data 0x8, tdo_i=1 -> TMS 1,1,0,0,0,0,0,1,1,0 (10 edges); tdi_o=0,0,0,1 in shift cycles; rsp_data_o=0xF.
4. TCK_DIV=3, SHIFT_DR, len code 63, data 0xDEADBEEF01234567, loopback -> tck_o 3 clocks low / 3 clocks high; 69 TCK cycles; rsp_data_o=0xDEADBEEF01234567.
5. Pull wb_rst_ni low during bit 10 of a 32-bit DR scan -> tck_o=0, tms_o=1 same cycle; no rsp_valid_o; after release, 6-cycle auto-reset runs before cmd_ready_o=1.
6. IDLE, len code 9, cmd_valid_i held high throughout -> 10 TCK cycles with TMS=0; rsp_data_o=0; exactly one command accepted before rsp_valid_o, next accepted only after cmd_ready_o returns.
